// File: rtl/lab5_pkg.sv
// +--------------------------------------------------------------------+
// | lab5_pkg: shared constants and types for the Lab 5 stream blocks.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package lab5_pkg;

  localparam int LAB5_W     = 8;
  localparam int LAB5_CNT_W = 8;

  typedef enum logic [0:0] {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

endpackage

`default_nettype wire

// File: rtl/lab5_hold_reg.sv
// +--------------------------------------------------------------------+
// | lab5_hold_reg: one-entry valid/ready holding register.             |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module lab5_hold_reg
  import lab5_pkg::*;
#(
  parameter int W = LAB5_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  hold_state_t  r_state;
  hold_state_t  w_state_nxt;
  logic [W-1:0] r_data;
  logic         w_drain;

  assign w_drain = (r_state == HOLD_FULL) & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HOLD_EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (load) r_data <= load_data;
    end
  end

  // A load while draining keeps the entry full with the newer word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HOLD_EMPTY: if (load) w_state_nxt = HOLD_FULL;
      HOLD_FULL:  if (load) w_state_nxt = HOLD_FULL;
                  else if (w_drain) w_state_nxt = HOLD_EMPTY;
      default:    w_state_nxt = HOLD_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (r_state == HOLD_FULL);
    out_data  = r_data;
  end

endmodule

`default_nettype wire

// File: rtl/lab5com6_stream_demux.sv
// +--------------------------------------------------------------------+
// | lab5com6_stream_demux: registered 1-to-2 valid/ready demux.        |
// | Optional delivered-word counters with DEMUX_STATS_EN.              |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module lab5com6_stream_demux
  import lab5_pkg::*;
#(
  parameter int W = LAB5_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sel,
  input  logic [W-1:0]          in_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [W-1:0]          out0_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [W-1:0]          out1_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [LAB5_CNT_W-1:0] cnt0,
  output logic [LAB5_CNT_W-1:0] cnt1
`endif
);

  logic w_load0;
  logic w_load1;

  // Only the selected output's occupancy gates acceptance; in_valid is not used.
  assign in_ready = in_sel ? (~out1_valid | out1_ready)
                           : (~out0_valid | out0_ready);

  assign w_load0 = in_valid & in_ready & ~in_sel;
  assign w_load1 = in_valid & in_ready &  in_sel;

  lab5_hold_reg #(.W(W)) u_hold0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load0),
    .load_data (in_data),
    .out_ready (out0_ready),
    .out_valid (out0_valid),
    .out_data  (out0_data)
  );

  lab5_hold_reg #(.W(W)) u_hold1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load1),
    .load_data (in_data),
    .out_ready (out1_ready),
    .out_valid (out1_valid),
    .out_data  (out1_data)
  );

`ifdef DEMUX_STATS_EN
  localparam logic [LAB5_CNT_W-1:0] c_cnt_max = '1;

  logic [LAB5_CNT_W-1:0] r_cnt0;
  logic [LAB5_CNT_W-1:0] r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready && r_cnt0 != c_cnt_max) r_cnt0 <= r_cnt0 + 1'b1;
      if (out1_valid && out1_ready && r_cnt1 != c_cnt_max) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

`default_nettype wire

// File: doc/lab5com6_stream_demux.md
# lab5com6_stream_demux

Registered 1-to-2 stream demultiplexer. It is the inverse of the lab's 2-to-1 multiplexer: one valid/ready input stream is routed, word by word, to one of two output streams chosen by a select bit that travels with each word. Each output has a one-entry holding register, so a stalled output never blocks traffic bound for the other output once that word is accepted. It sits between a single producer and two independent consumers in the Lab 5 datapath.

## Interface
Parameters:
- `W`, default 8: data width in bits.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: producer presents a word.
- `in_ready` out 1: block accepts a word this cycle.
- `in_sel` in 1: destination; 0 routes to out0, 1 routes to out1. Qualified by `in_valid`.
- `in_data` in W: payload.
- `out0_valid` out 1, `out0_ready` in 1, `out0_data` out W: output stream 0.
- `out1_valid` out 1, `out1_ready` in 1, `out1_data` out W: output stream 1.
- `cnt0`, `cnt1` out 8: delivered-word counters. Present only with `DEMUX_STATS_EN`.

## Operation
- Each output k has one holding register (`full_k`, `data_k`) with two states.
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on simultaneous drain and load; `data_k` takes the new word.
- Load into k: `in_valid & in_ready & (in_sel == k)`.
- Drain of k: `outk_valid & outk_ready`.
- `outk_valid = full_k`.
- `outk_data = data_k`.
- `in_ready = ~full_sel | outsel_ready`, where sel is `in_sel`.
  - Combinational from `in_sel`, `full` and the selected `out_ready`.
  - Does not depend on `in_valid`.
- The output that is not selected is unaffected by the input: it keeps its data and drains independently.
- Word order is preserved within each output. There is no ordering guarantee across the two outputs.
- Once a producer asserts `in_valid`, it holds `in_valid`, `in_sel` and `in_data` stable until `in_ready`. The block does not check this.
- Reset (asynchronous, any cycle, including while words are held):
  - `full_0 = full_1 = 0`, `data_0 = data_1 = 0`.
  - Therefore `out0_valid = out1_valid = 0` and `out*_data = 0`.
  - `in_ready = 1`.
  - Held words are discarded.
- Once asserted, `outk_valid` stays high until a drain.

## Timing
- Latency: a word accepted on edge N appears on `outk_valid`/`outk_data` after edge N, i.e. it is presentable for handshake in cycle N+1.
- Throughput: one word per cycle sustained to a single output, provided that output's `out_ready` is held high. This relies on the simultaneous load/drain case.
- Alternating destinations with both readies high also sustain one word per cycle.
- Back-pressure: when `full_k = 1`, `outk_ready = 0` and `in_sel = k`, then `in_ready = 0`. No load occurs and no data is lost.
- No combinational path from `in_valid`/`in_data` to any output signal.

## Configuration
- `DEMUX_STATS_EN` defined:
  - Ports `cnt0` and `cnt1` exist.
  - `cntk` increments on every drain of output k and saturates at 255.
  - Both counters reset to 0 asynchronously with `rst_n`.
- `DEMUX_STATS_EN` undefined:
  - Ports and counter logic are absent.
  - All other behaviour is identical.

## Structure
- Shared package `lab5_pkg`:
  - default data width constant `LAB5_W = 8`;
  - holding-register state enum `hold_state_t` with values `HOLD_EMPTY` and `HOLD_FULL`;
  - counter width constant `LAB5_CNT_W = 8`.
- One sub-module, `lab5_hold_reg`:
  - a one-entry valid/ready holding register with load and drain;
  - parameterised by `W`;
  - instantiated twice.
- The top level contains the `in_ready` select logic and the optional counters.

## Test plan
- Reset with `in_valid = 0` -> `in_ready = 1`, both `out*_valid = 0`, both `out*_data = 0`, `cnt0 = cnt1 = 0`.
- Send 0xA5 with `in_sel = 0` and 0x3C with `in_sel = 1` on consecutive cycles, both readies high:
  - `out0` shows 0xA5 one cycle after acceptance;
  - `out1` shows 0x3C one cycle after its own acceptance;
  - `cnt0 = cnt1 = 1`.
- Hold `out0_ready = 0` and send 0x11 then 0x22 to output 0:
  - 0x11 is held;
  - `in_ready = 0` while 0x22 waits;
  - raise `out0_ready` -> 0x11 is delivered, then 0x22, in order, with no loss.
- Same stalled `out0` holding 0x11, then send 0x77 with `in_sel = 1`:
  - `in_ready = 1`;
  - 0x77 is delivered on `out1` while `out0` still holds 0x11.
- Stream 0x00..0x0F to output 0 with `out0_ready` held high:
  - one word per cycle;
  - `out0_valid` stays high throughout;
  - data appears in order.
- Assert `rst_n = 0` mid-cycle while both outputs are FULL -> immediately both `out*_valid = 0` and `in_ready = 1`, without waiting for a clock edge.
- Counter saturation check, with `DEMUX_STATS_EN`: deliver 300 words to output 1 -> `cnt1 = 255`.
